// File: rtl/magia_pkg.sv
// Shared MAGIA definitions for the Fractal Sync tree and its tile-side controllers.
// The request/response payloads are sized by the number of tree levels.
package magia_pkg;

    localparam int unsigned FSYNC_LVL    = 7;
    localparam int unsigned TILE_FSYNC_W = FSYNC_LVL;

    typedef struct packed {
        logic [TILE_FSYNC_W-1:0] aggr;
    } fsync_req_t;

    typedef struct packed {
        logic [TILE_FSYNC_W-1:0] aggr;
    } fsync_rsp_t;

endpackage

// File: rtl/magia_fsync_ctrl.sv
// Tile-side Fractal Sync controller: issues one barrier at a time to the tree,
// waits for its completion and reports done, mismatch, timeout or spurious responses.
module magia_fsync_ctrl
    import magia_pkg::*;
#(
    parameter int unsigned      LVL_W   = TILE_FSYNC_W,
    parameter int unsigned      TMO_W   = 16,
    parameter logic [TMO_W-1:0] TMO_CYC = 16'hFFFF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [LVL_W-1:0] cfg_aggr_i,
    output logic             fsync_req_valid_o,
    input  logic             fsync_req_ready_i,
    output logic [LVL_W-1:0] fsync_req_aggr_o,
    input  logic             fsync_rsp_valid_i,
    input  logic [LVL_W-1:0] fsync_rsp_aggr_i,
    output logic             done_irq_o,
    output logic             busy_o,
    output logic             err_o,
    input  logic             err_clr_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_e;

    localparam bit               TMO_EN   = (TMO_CYC != '0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYC - 1'b1;

    state_e           state_q, state_d;
    logic [LVL_W-1:0] aggr_q, aggr_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             err_set;

    // NOTE: every signal gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        aggr_d  = aggr_q;
        cnt_d   = cnt_q;
        err_set = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_valid_i) begin
                    aggr_d  = cfg_aggr_i;
                    state_d = (cfg_aggr_i != '0) ? ST_REQ : ST_DONE;
                end
            end
            ST_REQ: begin
                if (fsync_req_ready_i) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (fsync_rsp_valid_i) begin
                    state_d = ST_DONE;
                    err_set = (fsync_rsp_aggr_i != aggr_q);
                end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
                    state_d = ST_DONE;
                    err_set = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A response the controller is not waiting for is flagged but otherwise ignored.
        if (fsync_rsp_valid_i && (state_q != ST_WAIT)) begin
            err_set = 1'b1;
        end

        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            aggr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            aggr_q  <= aggr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode only registered state, keeping inputs off any output path.
    assign cfg_ready_o       = (state_q == ST_IDLE);
    assign busy_o            = (state_q != ST_IDLE);
    assign fsync_req_valid_o = (state_q == ST_REQ);
    assign fsync_req_aggr_o  = aggr_q;
    assign done_irq_o        = (state_q == ST_DONE);
    assign err_o             = err_q;

endmodule

// File: tb/tb_magia_fsync_ctrl.sv
// Self-checking bench for magia_fsync_ctrl: a table of barrier transactions with
// expected IRQ cycle and error, plus hand-written corner sequences and an IRQ scoreboard.
module tb_magia_fsync_ctrl;
    import magia_pkg::*;

    localparam int LVL_W = TILE_FSYNC_W;
    localparam int TMO_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [LVL_W-1:0] cfg_aggr = '0;
    logic             req_valid;
    logic             req_ready = 1'b0;
    logic [LVL_W-1:0] req_aggr;
    logic             rsp_valid = 1'b0;
    logic [LVL_W-1:0] rsp_aggr = '0;
    logic             done_irq;
    logic             busy;
    logic             err;
    logic             err_clr = 1'b0;

    int total = 0;
    int bad   = 0;
    bit sb[$];

    always #5 clk = ~clk;

    magia_fsync_ctrl #(
        .LVL_W  (LVL_W),
        .TMO_W  (TMO_W),
        .TMO_CYC(16'd8)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .cfg_valid_i      (cfg_valid),
        .cfg_ready_o      (cfg_ready),
        .cfg_aggr_i       (cfg_aggr),
        .fsync_req_valid_o(req_valid),
        .fsync_req_ready_i(req_ready),
        .fsync_req_aggr_o (req_aggr),
        .fsync_rsp_valid_i(rsp_valid),
        .fsync_rsp_aggr_i (rsp_aggr),
        .done_irq_o       (done_irq),
        .busy_o           (busy),
        .err_o            (err),
        .err_clr_i        (err_clr)
    );

    typedef struct {
        logic [LVL_W-1:0] aggr;
        logic [LVL_W-1:0] rsp_aggr;
        int               rdly;     // cycles ready is held low while requesting
        int               rspdly;   // WAIT cycles before the response
        bit               respond;
        bit               refuse;   // push extra cfg requests while busy
        int               exp_irq;  // cycle of done_irq, accept = cycle 0
        bit               exp_err;
    } txn_t;

    txn_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every IRQ must match a queued expectation of the error flag at that moment.
    always @(negedge clk) begin
        if (rst_n && done_irq) begin
            if (sb.size() == 0) begin
                check("unexpected_irq", 32'(done_irq), 32'd0);
            end else begin
                check("sb_err_at_irq", 32'(err), 32'(sb.pop_front()));
            end
        end
    end

    task automatic run_txn(input txn_t t);
        int h;
        h = 1 + t.rdly;
        check("idle_cfg_ready", 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1;
        cfg_aggr  = t.aggr;
        err_clr   = 1'b1;
        sb.push_back(t.exp_err);
        for (int c = 1; c <= t.exp_irq + 1; c++) begin
            @(negedge clk);
            check("irq_timing", 32'(done_irq), 32'(c == t.exp_irq));
            check("req_valid", 32'(req_valid), 32'((t.aggr != '0) && (c <= h)));
            if (req_valid) check("req_aggr", 32'(req_aggr), 32'(t.aggr));
            check("cfg_ready", 32'(cfg_ready), 32'(c == t.exp_irq + 1));
            check("busy", 32'(busy), 32'(c <= t.exp_irq));
            if (c == 1) check("err_cleared", 32'(err), 32'd0);
            err_clr   = 1'b0;
            cfg_valid = t.refuse && (t.aggr != '0) && (c <= h);
            cfg_aggr  = ~t.aggr;
            req_ready = (c == h);
            rsp_valid = t.respond && (c == h + 1 + t.rspdly);
            rsp_aggr  = t.rsp_aggr;
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{7'h03, 7'h03, 0, 0, 1'b1, 1'b0, 3,  1'b0}; // basic
        tbl[1] = '{7'h7F, 7'h7F, 5, 0, 1'b1, 1'b1, 8,  1'b0}; // backpressure
        tbl[2] = '{7'h0F, 7'h07, 0, 0, 1'b1, 1'b0, 3,  1'b1}; // mismatch
        tbl[3] = '{7'h00, 7'h00, 0, 0, 1'b0, 1'b0, 1,  1'b0}; // zero aggregate
        tbl[4] = '{7'h55, 7'h00, 0, 0, 1'b0, 1'b0, 10, 1'b1}; // timeout
        tbl[5] = '{7'h21, 7'h21, 2, 3, 1'b1, 1'b1, 8,  1'b0}; // delayed ready and response
        tbl[6] = '{7'h40, 7'h40, 0, 1, 1'b1, 1'b0, 4,  1'b0}; // top level only

        repeat (2) @(negedge clk);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_irq", 32'(done_irq), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_aggr", 32'(req_aggr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

        // Mismatch, then a clear racing a spurious response: set wins.
        run_txn(tbl[2]);
        @(negedge clk);
        check("mm_err_sticky", 32'(err), 32'd1);
        err_clr   = 1'b1;
        rsp_valid = 1'b1;
        @(negedge clk);
        check("clr_vs_set_err", 32'(err), 32'd1);
        check("spurious_idle", 32'(cfg_ready), 32'd1);
        check("spurious_busy", 32'(busy), 32'd0);
        rsp_valid = 1'b0;
        @(negedge clk);
        check("clr_err", 32'(err), 32'd0);
        err_clr = 1'b0;

        // Timeout, then the late response is spurious.
        run_txn(tbl[4]);
        rsp_valid = 1'b1;
        rsp_aggr  = 7'h55;
        @(negedge clk);
        rsp_valid = 1'b0;
        check("late_rsp_err", 32'(err), 32'd1);
        check("late_rsp_busy", 32'(busy), 32'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("tmo_clr_err", 32'(err), 32'd0);

        // Reset while waiting on the tree, with err already set.
        rsp_valid = 1'b1;
        @(negedge clk);
        rsp_valid = 1'b0;
        check("spurious_set", 32'(err), 32'd1);
        cfg_valid = 1'b1;
        cfg_aggr  = 7'h03;
        @(negedge clk);
        check("rw_req_valid", 32'(req_valid), 32'd1);
        cfg_valid = 1'b0;
        req_ready = 1'b1;
        @(negedge clk);
        check("rw_in_wait", 32'(busy), 32'd1);
        req_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rw_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rw_req_valid0", 32'(req_valid), 32'd0);
        check("rw_irq", 32'(done_irq), 32'd0);
        check("rw_busy", 32'(busy), 32'd0);
        check("rw_err", 32'(err), 32'd0);
        check("rw_aggr", 32'(req_aggr), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_valid = 1'b1;
        rsp_aggr  = 7'h03;
        @(negedge clk);
        rsp_valid = 1'b0;
        check("post_rst_spurious", 32'(err), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("post_rst_clr", 32'(err), 32'd0);
        run_txn(tbl[0]);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
